gpio_ctrl: RTL and testbench
============================

// Module: gpio_ctrl
// PURPOSE
//  Parametrised memory-mapped GPIO controller for the single-cycle core's 7-bit data-address space.
//  Provides per-pin direction, output data and output mask, and a synchronised input register.
//  Adds rising/falling edge interrupts with write-1-to-clear status and an output toggle register.
//  Sits beside the data RAM on the core's A/WriteData/ReadDataMem path; irq goes to the system.
// PARAMETERS
//  PIN          8      number of GPIO pins, 1..32
//  ADDR_W       7      bus address width
//  BASE         7'h78  register window base; low 3 bits must be 0 (window = BASE..BASE+7)
//  SYNC_STAGES  2      input synchroniser flops, >=2
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       reset, asynchronous, active-low
//  addr      in   ADDR_W  register address
//  wdata     in   32      write data; bits [PIN-1:0] used
//  we        in   1       write strobe, one transfer per cycle
//  re        in   1       read strobe
//  rdata     out  32      read data, zero-extended above PIN
//  rvalid    out  1       rdata valid, one cycle after re
//  gpio_in   in   PIN     asynchronous pad inputs
//  gpio_out  out  PIN     pad output data = OUT & MASK & DIR
//  gpio_oe   out  PIN     pad output enable = DIR
//  irq       out  1       |STAT, level
// BEHAVIOUR
//  Hit = addr[ADDR_W-1:3]==BASE[ADDR_W-1:3]; offset = addr[2:0]. Registers, all PIN bits wide:
//   0 DIR      RW  1 = output
//   1 OUT      RW  output data
//   2 MASK     RW  output mask
//   3 IN       RO  synchronised gpio_in; writes ignored
//   4 RISE_EN  RW  rising-edge interrupt enable
//   5 FALL_EN  RW  falling-edge interrupt enable
//   6 STAT     W1C pending edges; writing 1 clears, writing 0 has no effect
//   7 TOGGLE   WO  OUT <= OUT ^ wdata; reads return 0
//  Reset: all registers, sync chain, edge flop, rdata, rvalid = 0; gpio_out = gpio_oe = 0; irq = 0.
//  Writes: take effect on the clk edge where we=1 and hit; gpio_out/gpio_oe update the same edge.
//  Reads: rdata/rvalid registered; re at cycle N -> rvalid=1 and rdata valid at N+1, else rvalid=0.
//   rdata holds its last value while rvalid=0.
//   Miss or offset 7: rdata=0, rvalid still 1. Miss writes are ignored.
//   we and re both asserted to the same register: read returns the pre-write value.
//  Input path: gpio_in -> SYNC_STAGES flops -> IN. A change at the pads is visible in IN SYNC_STAGES edges later.
//   One extra flop (IN_d) holds the previous IN.
//  Edge detection, per pin i, only while DIR[i]=0:
//   rise = IN[i] & ~IN_d[i] & RISE_EN[i]; fall = ~IN[i] & IN_d[i] & FALL_EN[i].
//   STAT[i] sets on the edge after detection, so it is SYNC_STAGES+1 cycles after the pad change.
//  Simultaneous set and W1C on the same bit: set wins, and STAT stays 1.
//  Clearing an enable does not clear pending STAT. Output-mode pins never set STAT.
//  After reset deassertion, a pin held high yields a rise edge; it is lost because RISE_EN=0 then.
//  Async reset mid-operation: all state returns to reset values immediately; a pending read is dropped (rvalid=0).
// TESTING
//  1 Reset: rst_n=0 with gpio_in=8'hFF -> gpio_out=0, gpio_oe=0, irq=0, rvalid=0. Release; read IN after 3 cycles -> 8'hFF.
//  2 Output: write DIR=8'h0F, MASK=8'h0C, OUT=8'hFF -> gpio_oe=8'h0F, gpio_out=8'h0C the next cycle.
//    Write TOGGLE=8'h04 -> gpio_out=8'h08; read OUT -> 8'hFB.
//  3 Rise IRQ: DIR=0, RISE_EN=8'h01, gpio_in[0] 0->1 at cycle N -> STAT=8'h01 and irq=1 at N+3.
//    Write STAT=8'h01 -> irq=0 the next cycle.
//  4 Collision: fall edge on pin 3 (FALL_EN=8'h08) detected in the same cycle as STAT write 8'h08 -> STAT[3] stays 1.
//    A write of 8'h00 to STAT leaves it set.
//  5 Bus edges: read 7'h40 -> rvalid=1, rdata=0. Write 7'h40 -> no register changes.
//    Write IN=8'hAA -> IN unchanged. Read and write DIR in the same cycle -> old value returned.
//  6 Reset mid-read: re=1 at cycle N, rst_n=0 during N -> rvalid=0 at N+1. DIR=0 and STAT=0 after release.

Source files
------------

// File: rtl/gpio_ctrl_if.sv
// Register-bus bundle between the core's data path and gpio_ctrl.
interface gpio_ctrl_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              we;
  logic              re;
  logic [31:0]       rdata;
  logic              rvalid;

  modport master (output addr, wdata, we, re, input rdata, rvalid);
  modport slave  (input addr, wdata, we, re, output rdata, rvalid);
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: direction/out/mask, synchronised inputs, edge IRQs with W1C status, toggle.
module gpio_ctrl #(
  parameter int unsigned       PIN         = 8,
  parameter int unsigned       ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(7'h78),
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_ctrl_if.slave       bus,
  input  logic [PIN-1:0]   gpio_in,
  output logic [PIN-1:0]   gpio_out,
  output logic [PIN-1:0]   gpio_oe,
  output logic             irq
);

  localparam logic [2:0] OFS_DIR  = 3'd0;
  localparam logic [2:0] OFS_OUT  = 3'd1;
  localparam logic [2:0] OFS_MASK = 3'd2;
  localparam logic [2:0] OFS_IN   = 3'd3;
  localparam logic [2:0] OFS_RISE = 3'd4;
  localparam logic [2:0] OFS_FALL = 3'd5;
  localparam logic [2:0] OFS_STAT = 3'd6;
  localparam logic [2:0] OFS_TOG  = 3'd7;

  logic [SYNC_STAGES-1:0][PIN-1:0] sync;
  logic [PIN-1:0] in_q, in_d;
  logic [PIN-1:0] dir_q, out_q, mask_q, rise_q, fall_q, stat_q;
  logic [PIN-1:0] dir_n, out_n, mask_n, rise_n, fall_n, stat_n;
  logic [PIN-1:0] wd, detect, rd_val;
  logic           hit, wr;
  logic [2:0]     ofs;

  assign in_q = sync[SYNC_STAGES-1];

  // Upper write-data bits are architecturally ignored when PIN < 32.
  if (PIN < 32) begin : g_wdata_pad
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[31:PIN];
  end

  // Address decode, register next-state and read mux.
  always_comb begin
    hit    = bus.addr[ADDR_W-1:3] == BASE[ADDR_W-1:3];
    ofs    = bus.addr[2:0];
    wr     = bus.we & hit;
    wd     = bus.wdata[PIN-1:0];
    dir_n  = dir_q;
    out_n  = out_q;
    mask_n = mask_q;
    rise_n = rise_q;
    fall_n = fall_q;
    stat_n = stat_q;
    rd_val = '0;

    if (wr) begin
      case (ofs)
        OFS_DIR:  dir_n  = wd;
        OFS_OUT:  out_n  = wd;
        OFS_MASK: mask_n = wd;
        OFS_RISE: rise_n = wd;
        OFS_FALL: fall_n = wd;
        OFS_STAT: stat_n = stat_q & ~wd;
        OFS_TOG:  out_n  = out_q ^ wd;
        default:  ;
      endcase
    end

    // Edges only count on input-mode pins; a new edge beats a same-cycle clear.
    detect = ~dir_q & ((in_q & ~in_d & rise_q) | (~in_q & in_d & fall_q));
    stat_n = stat_n | detect;

    if (hit) begin
      case (ofs)
        OFS_DIR:  rd_val = dir_q;
        OFS_OUT:  rd_val = out_q;
        OFS_MASK: rd_val = mask_q;
        OFS_IN:   rd_val = in_q;
        OFS_RISE: rd_val = rise_q;
        OFS_FALL: rd_val = fall_q;
        OFS_STAT: rd_val = stat_q;
        default:  rd_val = '0;
      endcase
    end
  end

  // State, registered pad outputs and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      in_d       <= '0;
      dir_q      <= '0;
      out_q      <= '0;
      mask_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      stat_q     <= '0;
      gpio_out   <= '0;
      gpio_oe    <= '0;
      irq        <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], gpio_in};
      in_d       <= in_q;
      dir_q      <= dir_n;
      out_q      <= out_n;
      mask_q     <= mask_n;
      rise_q     <= rise_n;
      fall_q     <= fall_n;
      stat_q     <= stat_n;
      gpio_out   <= out_n & mask_n & dir_n;
      gpio_oe    <= dir_n;
      irq        <= |stat_n;
      bus.rvalid <= bus.re;
      if (bus.re) bus.rdata <= 32'(rd_val);
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: pad history delay-line model, queued read expectations.
module tb_gpio_ctrl;
  localparam int unsigned PIN  = 8;
  localparam int unsigned AW   = 7;
  localparam int unsigned SYNC = 2;
  localparam logic [6:0]  BASE = 7'h78;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gpio_in, gpio_out, gpio_oe;
  logic       irq;

  gpio_ctrl_if #(.ADDR_W(AW)) bus ();

  gpio_ctrl #(.PIN(PIN), .ADDR_W(AW), .BASE(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [7:0]  m_dir, m_out, m_mask, m_rise, m_fall, m_stat;
  logic [7:0]  hist[$];          // hist[k] = pad value sampled k edges ago
  logic [31:0] exp_q[$];
  logic        exp_rvalid, exp_irq;
  logic [7:0]  exp_out, exp_oe, pad_v;
  logic [31:0] e_rd;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    {m_dir, m_out, m_mask, m_rise, m_fall, m_stat} = '0;
    hist = {};
    for (int i = 0; i <= SYNC; i++) hist.push_back(8'h00);
    exp_q.delete();
    exp_rvalid = 1'b0;
    exp_irq    = 1'b0;
    exp_out    = 8'h00;
    exp_oe     = 8'h00;
  endtask

  // One clock edge of the register map as described by its rules.
  task automatic model_edge(input logic [6:0] a, input logic [31:0] wdv, input logic we,
                            input logic re, input logic [7:0] pad);
    logic [7:0] in_v, in_prev, det, w, rv;
    logic [2:0] ofs;
    logic       hit;
    in_v    = hist[SYNC-1];
    in_prev = hist[SYNC];
    hit     = (a >> 3) == (BASE >> 3);
    ofs     = a[2:0];
    w       = wdv[7:0];
    if (re) begin
      rv = 8'h00;
      if (hit) begin
        case (ofs)
          3'd0: rv = m_dir;   3'd1: rv = m_out;  3'd2: rv = m_mask; 3'd3: rv = in_v;
          3'd4: rv = m_rise;  3'd5: rv = m_fall; 3'd6: rv = m_stat; default: rv = 8'h00;
        endcase
      end
      exp_q.push_back({24'h0, rv});
    end
    exp_rvalid = re;
    det = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (!m_dir[i] && in_v[i] && !in_prev[i] && m_rise[i]) det[i] = 1'b1;
      if (!m_dir[i] && !in_v[i] && in_prev[i] && m_fall[i]) det[i] = 1'b1;
    end
    if (we && hit) begin
      case (ofs)
        3'd0: m_dir  = w;
        3'd1: m_out  = w;
        3'd2: m_mask = w;
        3'd4: m_rise = w;
        3'd5: m_fall = w;
        3'd6: m_stat = m_stat & ~w;
        3'd7: m_out  = m_out ^ w;
        default: ;
      endcase
    end
    m_stat = m_stat | det;
    hist.push_front(pad);
    void'(hist.pop_back());
    exp_out = m_out & m_mask & m_dir;
    exp_oe  = m_dir;
    exp_irq = |m_stat;
  endtask

  task automatic step(input logic [6:0] a, input logic [31:0] wdv, input logic we, input logic re);
    @(negedge clk);
    bus.addr = a; bus.wdata = wdv; bus.we = we; bus.re = re; gpio_in = pad_v;
    @(posedge clk);
    if (rst_n) model_edge(a, wdv, we, re, pad_v);
  endtask

  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    step(7'(BASE + 7'(o)), {24'h0, d}, 1'b1, 1'b0);
  endtask
  task automatic rd(input logic [2:0] o);
    step(7'(BASE + 7'(o)), 32'h0, 1'b0, 1'b1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7'h00, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle compares pad outputs, irq, rvalid; pops expected read data on rvalid.
  always @(negedge clk) begin
    check("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
    if (bus.rvalid) begin
      if (exp_q.size() == 0) check("rdata_unexpected", 32'(1), 32'(0));
      else begin
        e_rd = exp_q.pop_front();
        check("rdata", bus.rdata, e_rd);
      end
    end
    check("gpio_out", 32'(gpio_out), 32'(exp_out));
    check("gpio_oe", 32'(gpio_oe), 32'(exp_oe));
    check("irq", 32'(irq), 32'(exp_irq));
  end

  logic [6:0]  ra;
  logic [31:0] rw;
  initial begin
    model_reset();
    pad_v = 8'hFF;
    gpio_in = pad_v;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;

    // Reset with pads high, then read synchronised inputs
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rd(3'd3);

    // Output path and toggle
    wr(3'd0, 8'h0F); wr(3'd2, 8'h0C); wr(3'd1, 8'hFF);
    #1 check("t2_oe", 32'(gpio_oe), 32'h0F);
    check("t2_out", 32'(gpio_out), 32'h0C);
    wr(3'd7, 8'h04);
    #1 check("t2_toggle", 32'(gpio_out), 32'h08);
    rd(3'd1); rd(3'd7);

    // Rising-edge interrupt on pin 0
    wr(3'd0, 8'h00); wr(3'd4, 8'h01); wr(3'd5, 8'h00);
    pad_v = 8'h00; idle(3); wr(3'd6, 8'hFF);
    pad_v = 8'h01; idle(2);
    #1 check("t3_irq_early", 32'(irq), 32'h0);
    idle(1);
    #1 check("t3_irq_set", 32'(irq), 32'h1);
    rd(3'd6);
    wr(3'd6, 8'h01);
    #1 check("t3_irq_clr", 32'(irq), 32'h0);

    // Fall edge on pin 3 colliding with a W1C of the same bit
    wr(3'd4, 8'h00); wr(3'd5, 8'h08);
    pad_v = 8'h09; idle(3); wr(3'd6, 8'hFF);
    pad_v = 8'h01; idle(2);
    wr(3'd6, 8'h08);
    #1 check("t4_collide_irq", 32'(irq), 32'h1);
    rd(3'd6);
    wr(3'd6, 8'h00); rd(3'd6);
    wr(3'd5, 8'h00); rd(3'd6);
    wr(3'd6, 8'h08); rd(3'd6);

    // Bus corner cases
    step(7'h40, 32'h0, 1'b0, 1'b1);
    step(7'h40, 32'hFF, 1'b1, 1'b0);
    rd(3'd0); rd(3'd1); rd(3'd2);
    wr(3'd3, 8'hAA); rd(3'd3);
    wr(3'd0, 8'h33);
    step(BASE, 32'h5A, 1'b1, 1'b1);
    rd(3'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'(BASE + 7'($urandom_range(0, 7)));
      rw = $urandom;
      if ($urandom_range(0, 3) == 0) pad_v = pad_v ^ 8'(1 << $urandom_range(0, 7));
      step(ra, rw, 1'($urandom), 1'($urandom));
    end

    // Async reset landing on a pending read
    wr(3'd0, 8'h30);
    @(negedge clk);
    bus.addr = BASE; bus.we = 1'b0; bus.re = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    bus.re = 1'b0;
    rst_n = 1'b1;
    rd(3'd0); rd(3'd6);
    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
